dht11_sensor_emu: RTL and testbench



---
 rtl/dht11_sensor_emu.sv | 100 ++++++++++
 tb/tb_dht11_sensor_emu.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dht11_sensor_emu.sv
`timescale 1ns/1ps
// dht11_sensor_emu: sensor side of the DHT11 single-wire protocol, answering a host start with preamble + data frame.
// Define DHT_EMU_CHECKSUM_EN to append the 8-bit checksum byte (40-bit frame instead of 32).
module dht11_sensor_emu #(
  parameter int CLK_FREQ       = 12_000_000,
  parameter int T_START_MIN_US = 18000,
  parameter int T_WAIT_US      = 30,
  parameter int T_RESP_LOW_US  = 80,
  parameter int T_RESP_HIGH_US = 82,
  parameter int T_BIT_LOW_US   = 54,
  parameter int T_BIT0_HIGH_US = 26,
  parameter int T_BIT1_HIGH_US = 70,
  parameter int T_END_LOW_US   = 54,
  parameter int T_COOLDOWN_US  = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_in,
  output logic        drive_low,
  input  logic [31:0] payload,
  output logic        busy,
  output logic        frame_done
);
`ifdef DHT_EMU_CHECKSUM_EN
  localparam int FRAME_BITS = 40;
`else
  localparam int FRAME_BITS = 32;
`endif
  localparam logic [15:0] DIV = 16'(CLK_FREQ / 1_000_000);
  typedef enum logic [3:0] {IDLE, START_LOW, WAIT_REL, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW, COOLDOWN} state_t;
  state_t state, state_nx;
  logic line_q, line_s, us_tick, done;
  logic [15:0] pre_cnt, us_cnt, phase_us;
  logic [5:0] bit_idx;
  logic [FRAME_BITS-1:0] sr, frame_init;
`ifdef DHT_EMU_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = payload[31:24] + payload[23:16] + payload[15:8] + payload[7:0];
  assign frame_init = {payload, csum};
`else
  assign frame_init = payload;
`endif
  assign us_tick = pre_cnt == DIV - 16'd1;
  assign drive_low = state inside {RESP_LOW, BIT_LOW, END_LOW};
  assign busy = !(state inside {IDLE, START_LOW});
  always_comb begin
    phase_us = state == WAIT_REL  ? 16'(T_WAIT_US) :
               state == RESP_LOW  ? 16'(T_RESP_LOW_US) :
               state == RESP_HIGH ? 16'(T_RESP_HIGH_US) :
               state == BIT_LOW   ? 16'(T_BIT_LOW_US) :
               state == BIT_HIGH  ? (sr[FRAME_BITS-1] ? 16'(T_BIT1_HIGH_US) : 16'(T_BIT0_HIGH_US)) :
               state == END_LOW   ? 16'(T_END_LOW_US) :
               state == COOLDOWN  ? 16'(T_COOLDOWN_US) : 16'd0;
    done = us_tick && us_cnt >= phase_us - 16'd1;
    state_nx = state;
    case (state)
      IDLE:      if (!line_s) state_nx = START_LOW;
      START_LOW: if (line_s) state_nx = us_cnt >= 16'(T_START_MIN_US) ? WAIT_REL : IDLE;
      WAIT_REL:  if (done) state_nx = RESP_LOW;
      RESP_LOW:  if (done) state_nx = RESP_HIGH;
      RESP_HIGH: if (done) state_nx = BIT_LOW;
      BIT_LOW:   if (done) state_nx = BIT_HIGH;
      BIT_HIGH:  if (done) state_nx = bit_idx == 6'(FRAME_BITS - 1) ? END_LOW : BIT_LOW;
      END_LOW:   if (done) state_nx = COOLDOWN;
      COOLDOWN:  if (done) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end
  // Line idles high, so the synchronizer resets to 1 to avoid a phantom start after reset.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      line_q <= 1'b1;
      line_s <= 1'b1;
      state <= IDLE;
      frame_done <= 1'b0;
      pre_cnt <= '0;
      us_cnt <= '0;
      sr <= '0;
      bit_idx <= '0;
    end else begin
      line_q <= line_in;
      line_s <= line_q;
      state <= state_nx;
      frame_done <= state == END_LOW && state_nx == COOLDOWN;
      if (state_nx != state) begin
        pre_cnt <= '0;
        us_cnt <= '0;
      end else begin
        pre_cnt <= us_tick ? '0 : pre_cnt + 16'd1;
        if (us_tick && us_cnt != 16'hFFFF) us_cnt <= us_cnt + 16'd1;
      end
      if (state == WAIT_REL && state_nx == RESP_LOW) begin
        sr <= frame_init;
        bit_idx <= '0;
      end else if (state == BIT_HIGH && done) begin
        sr <= sr << 1;
        bit_idx <= bit_idx + 6'd1;
      end
    end
endmodule

// File: tb/tb_dht11_sensor_emu.sv
`timescale 1ns/1ps
// tb_dht11_sensor_emu: scoreboard bench for dht11_sensor_emu at 2 MHz with shortened start/cooldown times.
module tb_dht11_sensor_emu;
  localparam int DIV = 2;
  localparam int T_START = 300;
  localparam int T_COOL = 500;
`ifdef DHT_EMU_CHECKSUM_EN
  localparam int FB = 40;
`else
  localparam int FB = 32;
`endif
  logic clk = 1'b0, reset = 1'b1, host_low = 1'b0;
  logic line_in, drive_low, busy, frame_done;
  logic [31:0] payload = 32'h0;
  int checks = 0, errors = 0, fd_cnt = 0;
  bit exp_q[$];

  assign line_in = ~(host_low | drive_low);
  always #5 clk = ~clk;
  always @(posedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

  dht11_sensor_emu #(.CLK_FREQ(2_000_000), .T_START_MIN_US(T_START), .T_COOLDOWN_US(T_COOL)) dut (
    .clk(clk), .reset(reset), .line_in(line_in), .drive_low(drive_low),
    .payload(payload), .busy(busy), .frame_done(frame_done)
  );

  task automatic push_frame(input logic [31:0] p);
    logic [7:0] cs;
    for (int i = 31; i >= 0; i--) exp_q.push_back(p[i]);
    cs = p[31:24] + p[23:16] + p[15:8] + p[7:0];
`ifdef DHT_EMU_CHECKSUM_EN
    for (int i = 7; i >= 0; i--) exp_q.push_back(cs[i]);
`endif
  endtask

  task automatic host_start(input int us);
    host_low = 1'b1;
    repeat (us * DIV) @(negedge clk);
    host_low = 1'b0;
  endtask

  task automatic measure(input logic lvl, input int limit, output int len);
    len = 0;
    while (drive_low === lvl && len < limit) begin
      @(negedge clk);
      len++;
    end
  endtask

  task automatic rx_frame(input string tag, input bit mutate, input bit wait_cool);
    int len, fd0, n;
    bit b, e;
    fd0 = fd_cnt;
    measure(1'b0, 1000, len);
    checks++;
    if (len < 30 * DIV || len > 30 * DIV + 4) begin errors++; $display("FAIL %s wait: got %0d cycles, want %0d..%0d", tag, len, 30 * DIV, 30 * DIV + 4); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_resp: got %b want 1", tag, busy); end
    measure(1'b1, 1000, len);
    checks++;
    if (len != 80 * DIV) begin errors++; $display("FAIL %s resp_low: got %0d want %0d", tag, len, 80 * DIV); end
    if (mutate) payload = 32'hFFFF_FFFF;
    measure(1'b0, 1000, len);
    checks++;
    if (len != 82 * DIV || busy !== 1'b1) begin errors++; $display("FAIL %s resp_high: got %0d busy %b want %0d busy 1", tag, len, busy, 82 * DIV); end
    for (int i = 0; i < FB; i++) begin
      measure(1'b1, 1000, len);
      checks++;
      if (len != 54 * DIV) begin errors++; $display("FAIL %s bit%0d_low: got %0d want %0d", tag, i, len, 54 * DIV); end
      measure(1'b0, 1000, len);
      b = len > (26 + 70) * DIV / 2;
      e = 1'b0;
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL %s bit%0d: scoreboard empty, got %b", tag, i, b); end
      else begin
        e = exp_q.pop_front();
        if (b !== e) begin errors++; $display("FAIL %s bit%0d value: got %b want %b", tag, i, b, e); end
      end
      checks++;
      if (len != (e ? 70 : 26) * DIV) begin errors++; $display("FAIL %s bit%0d_high: got %0d want %0d", tag, i, len, (e ? 70 : 26) * DIV); end
    end
    measure(1'b1, 1000, len);
    checks++;
    if (len != 54 * DIV || frame_done !== 1'b1) begin errors++; $display("FAIL %s end_low: got %0d done %b want %0d done 1", tag, len, frame_done, 54 * DIV); end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0 || fd_cnt - fd0 != 1) begin errors++; $display("FAIL %s frame_done pulse: got level %b count %0d want 0 and 1", tag, frame_done, fd_cnt - fd0); end
    if (wait_cool) begin
      n = 0;
      while (busy === 1'b1 && n < 4 * T_COOL * DIV) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n < T_COOL * DIV - 3 || n > T_COOL * DIV + 1) begin errors++; $display("FAIL %s cooldown: got %0d cycles want %0d..%0d", tag, n, T_COOL * DIV - 3, T_COOL * DIV + 1); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (drive_low !== 1'b0) begin errors++; $display("FAIL reset drive_low: got %b want 0", drive_low); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done: got %b want 0", frame_done); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_start_and_data();
    payload = 32'h3700_1A05;
    push_frame(payload);
    host_start(T_START + 20);
    rx_frame("data", 1'b0, 1'b1);
  endtask

  task automatic test_short_start();
    int act;
    act = 0;
    host_low = 1'b1;
    repeat (T_START / 2 * DIV) begin
      @(negedge clk);
      act += int'(busy | drive_low);
    end
    host_low = 1'b0;
    repeat (200 * DIV) begin
      @(negedge clk);
      act += int'(busy | drive_low);
    end
    checks++;
    if (act != 0) begin errors++; $display("FAIL short_start: got %0d active cycles want 0", act); end
  endtask

  task automatic test_latch_and_cooldown();
    int act, n;
    payload = 32'h3700_1A05;
    push_frame(payload);
    host_start(T_START + 20);
    rx_frame("latch", 1'b1, 1'b0);
    host_start(T_START + 20);
    n = 0;
    while (busy === 1'b1 && n < 4 * T_COOL * DIV) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL cooldown_end: busy got %b want 0", busy); end
    act = 0;
    repeat (300 * DIV) begin
      @(negedge clk);
      act += int'(busy | drive_low);
    end
    checks++;
    if (act != 0) begin errors++; $display("FAIL cooldown_start_ignored: got %0d active cycles want 0", act); end
    payload = 32'hA5C3_0F81;
    push_frame(payload);
    host_start(T_START + 20);
    rx_frame("after_cool", 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    int rises, n;
    logic prev;
    payload = 32'h3700_1A05;
    push_frame(payload);
    host_start(T_START + 20);
    rises = 0;
    n = 0;
    prev = 1'b0;
    while (rises < 12 && n < 20000) begin
      @(negedge clk);
      n++;
      if (drive_low === 1'b1 && prev === 1'b0) rises++;
      prev = drive_low;
    end
    checks++;
    if (rises != 12) begin errors++; $display("FAIL mid_frame reach bit10: got %0d rises want 12", rises); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (drive_low !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_frame reset: got drive_low %b busy %b want 0 0", drive_low, busy); end
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    payload = 32'h5A01_C0FE;
    push_frame(payload);
    host_start(T_START + 20);
    rx_frame("post_reset", 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_start_and_data();
    test_short_start();
    test_latch_and_cooldown();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard leftover: got %0d entries want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
